// File: rtl/aes_host_link_if.sv
// Byte-stream and encryptor-side signal bundle for aes_host_link.
// slave = the link block itself, master = the host/encryptor environment.
interface aes_host_link_if;
    logic [7:0]   i_byte;
    logic         i_byte_valid;
    logic         o_byte_ready;
    logic         o_start;
    logic         i_load;
    logic [127:0] o_data;
    logic         o_data_received_text;
    logic         o_data_received_key;
    logic         i_send;
    logic [127:0] i_cipher_text;
    logic [7:0]   o_byte;
    logic         o_byte_valid;
    logic         i_byte_ready;
    logic         o_done;

    modport slave (
        input  i_byte, i_byte_valid, i_load, i_send, i_cipher_text, i_byte_ready,
        output o_byte_ready, o_start, o_data, o_data_received_text,
               o_data_received_key, o_byte, o_byte_valid, o_done
    );

    modport master (
        output i_byte, i_byte_valid, i_load, i_send, i_cipher_text, i_byte_ready,
        input  o_byte_ready, o_start, o_data, o_data_received_text,
               o_data_received_key, o_byte, o_byte_valid, o_done
    );
endinterface

// File: rtl/aes_host_link.sv
// Host-side link partner for the AES encryptor: collects text/key bytes, serves load, drains ciphertext.
// Optional: HOST_LINK_KEY_REUSE_EN keeps the last key so later blocks only need 16 text bytes.
module aes_host_link (
    input  logic              clk,
    input  logic              reset,
    aes_host_link_if.slave    bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned ICNT_W = 5;
    localparam int unsigned OCNT_W = 4;

    typedef enum logic [2:0] {
        S_COLLECT, S_START, S_WAIT_LOAD, S_SEND_TEXT,
        S_SEND_KEY, S_WAIT_SEND, S_DRAIN, S_DONE
    } state_t;

    state_t              r_state, w_state_next;
    logic [ICNT_W-1:0]   r_in_cnt, w_in_cnt_next;
    logic [OCNT_W-1:0]   r_out_cnt, w_out_cnt_next;
    logic [BLK_W-1:0]    r_text, w_text_next;
    logic [BLK_W-1:0]    r_key, w_key_next;
    logic [BLK_W-1:0]    r_shift, w_shift_next;

    logic                r_byte_ready, w_byte_ready_next;
    logic                r_start, w_start_next;
    logic                r_rx_text, w_rx_text_next;
    logic                r_rx_key, w_rx_key_next;
    logic [BLK_W-1:0]    r_data, w_data_next;
    logic [BYTE_W-1:0]   r_byte, w_byte_next;
    logic                r_byte_valid, w_byte_valid_next;
    logic                r_done, w_done_next;

    logic                w_key_valid;
    logic                w_byte_take;
    logic                w_byte_give;
    logic                w_last_in;

`ifdef HOST_LINK_KEY_REUSE_EN
    logic r_key_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      r_key_valid <= 1'b0;
        else if (r_state == S_SEND_KEY) r_key_valid <= 1'b1;
    end

    assign w_key_valid = r_key_valid;
`else
    assign w_key_valid = 1'b0;
`endif

    // Ready/valid are only ever high in COLLECT/DRAIN, so they double as state qualifiers.
    assign w_byte_take = r_byte_ready & bus.i_byte_valid;
    assign w_byte_give = r_byte_valid & bus.i_byte_ready;
    assign w_last_in   = w_key_valid ? (r_in_cnt == ICNT_W'(15)) : (r_in_cnt == ICNT_W'(31));

    always_comb begin
        w_state_next   = r_state;
        w_in_cnt_next  = r_in_cnt;
        w_out_cnt_next = r_out_cnt;
        w_text_next    = r_text;
        w_key_next     = r_key;
        w_shift_next   = r_shift;

        case (r_state)
            S_COLLECT: begin
                if (w_byte_take) begin
                    // Shift-in gives big-endian order: first byte ends up in [127:120].
                    if (r_in_cnt[ICNT_W-1]) w_key_next  = {r_key[BLK_W-BYTE_W-1:0], bus.i_byte};
                    else                    w_text_next = {r_text[BLK_W-BYTE_W-1:0], bus.i_byte};
                    if (w_last_in) begin
                        w_in_cnt_next = '0;
                        w_state_next  = S_START;
                    end else begin
                        w_in_cnt_next = r_in_cnt + ICNT_W'(1);
                    end
                end
            end
            S_START:     w_state_next = S_WAIT_LOAD;
            S_WAIT_LOAD: if (bus.i_load) w_state_next = S_SEND_TEXT;
            S_SEND_TEXT: w_state_next = S_SEND_KEY;
            S_SEND_KEY:  w_state_next = S_WAIT_SEND;
            S_WAIT_SEND: begin
                if (bus.i_send) begin
                    w_shift_next = bus.i_cipher_text;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_byte_give) begin
                    w_shift_next   = {r_shift[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
                    w_out_cnt_next = r_out_cnt + OCNT_W'(1);
                    if (r_out_cnt == OCNT_W'(15)) w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_COLLECT;
            default: w_state_next = S_COLLECT;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        w_byte_ready_next = (w_state_next == S_COLLECT);
        w_start_next      = (w_state_next == S_START);
        w_rx_text_next    = (w_state_next == S_SEND_TEXT);
        w_rx_key_next     = (w_state_next == S_SEND_KEY);
        w_byte_valid_next = (w_state_next == S_DRAIN);
        w_done_next       = (w_state_next == S_DONE);
        w_byte_next       = w_byte_valid_next ? w_shift_next[BLK_W-1 -: BYTE_W] : BYTE_W'(0);
        w_data_next       = w_rx_text_next ? w_text_next :
                            w_rx_key_next  ? w_key_next  : BLK_W'(0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_COLLECT;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_text       <= '0;
            r_key        <= '0;
            r_shift      <= '0;
            r_byte_ready <= 1'b0;
            r_start      <= 1'b0;
            r_rx_text    <= 1'b0;
            r_rx_key     <= 1'b0;
            r_data       <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_in_cnt     <= w_in_cnt_next;
            r_out_cnt    <= w_out_cnt_next;
            r_text       <= w_text_next;
            r_key        <= w_key_next;
            r_shift      <= w_shift_next;
            r_byte_ready <= w_byte_ready_next;
            r_start      <= w_start_next;
            r_rx_text    <= w_rx_text_next;
            r_rx_key     <= w_rx_key_next;
            r_data       <= w_data_next;
            r_byte       <= w_byte_next;
            r_byte_valid <= w_byte_valid_next;
            r_done       <= w_done_next;
        end
    end

    assign bus.o_byte_ready         = r_byte_ready;
    assign bus.o_start              = r_start;
    assign bus.o_data_received_text = r_rx_text;
    assign bus.o_data_received_key  = r_rx_key;
    assign bus.o_data               = r_data;
    assign bus.o_byte               = r_byte;
    assign bus.o_byte_valid         = r_byte_valid;
    assign bus.o_done               = r_done;
endmodule

// File: tb/tb_aes_host_link.sv
// Scoreboard bench for aes_host_link: load data and ciphertext bytes are queued when driven, compared on output.
// Build with +define+HOST_LINK_KEY_REUSE_EN to also cover the key-reuse path.
module tb_aes_host_link;
    localparam logic [127:0] TEXT1  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] KEY1   = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] CIPH1  = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] TEXT2  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] KEY2   = 128'hA5A55A5A0123456789ABCDEFFEDCBA98;
    localparam logic [127:0] CIPH2  = 128'h00112233445566778899AABBCCDDEEFF;
`ifdef HOST_LINK_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [127:0] data_q[$];
    logic [7:0]   byte_q[$];

    aes_host_link_if bus();

    aes_host_link u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, "_ready"}, 128'(bus.o_byte_ready), 128'd0);
        check({tag, "_start"}, 128'(bus.o_start), 128'd0);
        check({tag, "_rxt"},   128'(bus.o_data_received_text), 128'd0);
        check({tag, "_rxk"},   128'(bus.o_data_received_key), 128'd0);
        check({tag, "_data"},  bus.o_data, 128'd0);
        check({tag, "_byte"},  128'(bus.o_byte), 128'd0);
        check({tag, "_bval"},  128'(bus.o_byte_valid), 128'd0);
        check({tag, "_done"},  128'(bus.o_done), 128'd0);
    endtask

    task automatic feed(input logic [127:0] t, input logic [127:0] k, input bit with_key);
        logic [255:0] stream;
        int n;
        stream = {t, k};
        n = with_key ? 32 : 16;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("in_ready", 128'(bus.o_byte_ready), 128'd1);
            check("early_start", 128'(bus.o_start), 128'd0);
            bus.i_byte       = stream[255 - 8*i -: 8];
            bus.i_byte_valid = 1'b1;
        end
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        check("start", 128'(bus.o_start), 128'd1);
        check("ready_in_start", 128'(bus.o_byte_ready), 128'd0);
        @(negedge clk);
        check("start_end", 128'(bus.o_start), 128'd0);
    endtask

    task automatic load(input logic [127:0] t, input logic [127:0] k);
        @(negedge clk);
        bus.i_load = 1'b1;
        data_q.push_back(t);
        data_q.push_back(k);
        @(negedge clk);
        bus.i_load = 1'b0;
        check("rx_text", 128'(bus.o_data_received_text), 128'd1);
        check("rx_text_k", 128'(bus.o_data_received_key), 128'd0);
        check("text_data", bus.o_data, data_q.pop_front());
        @(negedge clk);
        check("rx_key", 128'(bus.o_data_received_key), 128'd1);
        check("rx_key_t", 128'(bus.o_data_received_text), 128'd0);
        check("key_data", bus.o_data, data_q.pop_front());
        @(negedge clk);
        check("rx_idle_t", 128'(bus.o_data_received_text), 128'd0);
        check("rx_idle_k", 128'(bus.o_data_received_key), 128'd0);
        check("data_idle", bus.o_data, 128'd0);
    endtask

    task automatic drain(input logic [127:0] c, input int abort_at);
        logic [127:0] sh;
        int sent;
        int stall;
        int cyc;
        @(negedge clk);
        bus.i_send        = 1'b1;
        bus.i_cipher_text = c;
        bus.i_byte_ready  = 1'b0;
        sh = c;
        for (int i = 0; i < 16; i++) begin
            byte_q.push_back(sh[127:120]);
            sh = sh << 8;
        end
        sent = 0; stall = 0; cyc = 0;
        while (sent < 16 && cyc < 64) begin
            @(negedge clk);
            cyc++;
            bus.i_send        = 1'b0;
            bus.i_cipher_text = '0;
            if (sent == abort_at) begin
                reset = 1'b1;
                bus.i_byte_ready = 1'b0;
                #1;
                expect_all_zero("rst_drain");
                byte_q.delete();
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("ready_after_rst", 128'(bus.o_byte_ready), 128'd1);
                check("bval_after_rst", 128'(bus.o_byte_valid), 128'd0);
                return;
            end
            check("out_valid", 128'(bus.o_byte_valid), 128'd1);
            check("out_byte", 128'(bus.o_byte), 128'(byte_q[0]));
            check("done_early", 128'(bus.o_done), 128'd0);
            if (sent == 7 && stall < 3) begin
                bus.i_byte_ready = 1'b0;
                stall++;
            end else begin
                bus.i_byte_ready = 1'b1;
                void'(byte_q.pop_front());
                sent++;
            end
        end
        check("drain_count", 128'(sent), 128'd16);
        @(negedge clk);
        bus.i_byte_ready = 1'b0;
        check("done", 128'(bus.o_done), 128'd1);
        check("bval_in_done", 128'(bus.o_byte_valid), 128'd0);
        check("ready_in_done", 128'(bus.o_byte_ready), 128'd0);
        @(negedge clk);
        check("done_end", 128'(bus.o_done), 128'd0);
        check("ready_after_done", 128'(bus.o_byte_ready), 128'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.i_byte = '0;
        bus.i_byte_valid = 1'b0;
        bus.i_load = 1'b0;
        bus.i_send = 1'b0;
        bus.i_cipher_text = '0;
        bus.i_byte_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_first", 128'(bus.o_byte_ready), 128'd1);

        // Stray load/send while collecting must be ignored.
        bus.i_load = 1'b1;
        bus.i_send = 1'b1;
        bus.i_cipher_text = CIPH2;
        @(negedge clk);
        bus.i_load = 1'b0;
        bus.i_send = 1'b0;
        bus.i_cipher_text = '0;
        check("spur_rxt", 128'(bus.o_data_received_text), 128'd0);
        check("spur_bval", 128'(bus.o_byte_valid), 128'd0);
        check("spur_ready", 128'(bus.o_byte_ready), 128'd1);

        feed(TEXT1, KEY1, 1'b1);

        // Stray send while waiting for load.
        @(negedge clk);
        bus.i_send = 1'b1;
        bus.i_cipher_text = CIPH2;
        @(negedge clk);
        bus.i_send = 1'b0;
        bus.i_cipher_text = '0;
        check("wl_bval", 128'(bus.o_byte_valid), 128'd0);
        check("wl_rxt", 128'(bus.o_data_received_text), 128'd0);
        check("wl_ready", 128'(bus.o_byte_ready), 128'd0);

        load(TEXT1, KEY1);
        drain(CIPH1, -1);

        if (REUSE) begin
            feed(TEXT2, KEY2, 1'b0);
            load(TEXT2, KEY1);
            drain(CIPH2, -1);
        end

        feed(TEXT2, KEY2, !REUSE);
        load(TEXT2, REUSE ? KEY1 : KEY2);
        drain(CIPH1, 5);

        feed(TEXT1, KEY1, 1'b1);
        load(TEXT1, KEY1);
        drain(CIPH2, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_host_link.md
# aes_host_link

Host-side link partner for the AES encryption FSMs. It assembles a 16-byte plaintext and a 16-byte key from a byte stream, then starts the encryptor. It answers the encryptor's load request by presenting text and then key on the 128-bit data bus with received strobes. When the encryptor sends, it captures the ciphertext, streams it out byte-wise, and signals done.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- i_byte  input  8  inbound byte (text bytes, then key bytes)
- i_byte_valid  input  1  inbound byte valid
- o_byte_ready  output  1  block accepts inbound byte this cycle
- o_start  output  1  one-cycle start pulse to encryptor
- i_load  input  1  encryptor requests text/key
- o_data  output  128  text or key toward encryptor
- o_data_received_text  output  1  o_data holds plaintext (one-cycle strobe)
- o_data_received_key  output  1  o_data holds key (one-cycle strobe)
- i_send  input  1  encryptor presents ciphertext
- i_cipher_text  input  128  ciphertext, valid while i_send=1
- o_byte  output  8  outbound ciphertext byte
- o_byte_valid  output  1  outbound byte valid
- i_byte_ready  input  1  downstream accepts outbound byte
- o_done  output  1  one-cycle pulse: ciphertext fully delivered

## Operation
- States: COLLECT, START, WAIT_LOAD, SEND_TEXT, SEND_KEY, WAIT_SEND, DRAIN, DONE.
- COLLECT: o_byte_ready=1. A byte is taken when i_byte_valid & o_byte_ready.
  - A 5-bit counter tracks bytes 0..31. Bytes 0–15 form the text, 16–31 the key.
  - Ordering is big-endian: byte 0 → text[127:120], byte 15 → text[7:0], byte 16 → key[127:120].
  - When byte 31 is accepted, go to START and clear the counter.
- START: o_start=1 for one cycle, then WAIT_LOAD.
- WAIT_LOAD: wait for i_load=1, then SEND_TEXT.
- SEND_TEXT: o_data=text, o_data_received_text=1 for one cycle, then SEND_KEY.
- SEND_KEY: o_data=key, o_data_received_key=1 for one cycle, then WAIT_SEND.
- o_data is 0 in every state other than SEND_TEXT and SEND_KEY.
- WAIT_SEND: when i_send=1, load i_cipher_text into a 128-bit shift register and go to DRAIN.
- DRAIN:
  - o_byte_valid=1; o_byte = shift_reg[127:120].
  - On each i_byte_valid & i_byte_ready... specifically on each o_byte_valid & i_byte_ready, shift left 8 and increment a 4-bit counter.
  - After the 16th handshake, go to DONE.
  - o_byte is held stable while i_byte_ready=0.
- DONE: o_done=1 for one cycle, then COLLECT.
- Inputs are ignored outside their consuming states:
  - i_byte_valid outside COLLECT (o_byte_ready=0 there).
  - i_load outside WAIT_LOAD.
  - i_send outside WAIT_SEND.
- Reset, asynchronous and at any time including mid-transfer:
  - State → COLLECT; all counters, text, key and shift register → 0.
  - All outputs → 0, o_byte_ready included.
  - o_byte_ready rises in the first cycle after reset is released.

## Timing
- Last input byte accepted at edge N → o_start high in cycle N+1.
- i_load sampled high at edge M → o_data_received_text in cycle M+1, o_data_received_key in cycle M+2.
- i_send sampled high at edge P → first o_byte_valid in cycle P+1.
- Throughput is one byte per cycle when i_byte_ready stays high: 16 cycles to drain.
- 16th output handshake at edge Q → o_done in cycle Q+1 → o_byte_ready=1 in cycle Q+2.
- Only one strobe (o_start, received_text, received_key, o_done) is ever high in a given cycle.

## Configuration
- HOST_LINK_KEY_REUSE_EN defined:
  - A key_valid flag is set when SEND_KEY completes.
  - While key_valid=1, COLLECT accepts only 16 text bytes, then goes to START. The stored key is retained and resent in SEND_KEY.
  - reset clears key_valid.
- Undefined: every block collects 32 bytes (text and key).

## Test plan
- Reset mid-DRAIN: assert reset after 5 output bytes → all outputs 0 immediately; o_byte_ready=1 in the cycle after release; counter restarts at byte 0.
- Basic block:
  - Stimulus: stream text 5477_6F20_4F6E_6520_4E69_6E65_2054_776F, then key 5468_6174_7320_6D79_204B_756E_6720_4675.
  - Response: o_start one cycle after the last byte.
  - Pulse i_load → text strobe, then key strobe on consecutive cycles, with o_data equal to the exact values.
- Ciphertext delivery: i_send with i_cipher_text=29C3_505F_5714_20F6_4022_99B3_1A02_D73A → bytes 29,C3,50,...,D7,3A in order, then o_done one cycle after 3A is accepted.
- Backpressure: hold i_byte_ready low for 3 cycles at byte 7 → o_byte stays 0xF6, valid stays high, no byte lost or duplicated.
- Spurious inputs: pulse i_load during COLLECT and i_send during WAIT_LOAD → no state change, no strobes.
- With HOST_LINK_KEY_REUSE_EN: second block of 16 text bytes only → START after byte 15; SEND_KEY presents 5468...4675 again.
